// File: rtl/mem_access_unit.sv
//------------------------------------------------------------------------------
// mem_access_unit : RISC-V style load/store sequencer for a word-wide memory
// (read-modify-write for sub-word stores). Optional macro: MISALIGN_TRAP_EN.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module mem_access_unit #(
  parameter int WORDS      = 10,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  reset_ni,
  input  logic                  req_i,
  input  logic                  we_i,
  input  logic [2:0]            funct3_i,
  input  logic [WORDS+1:0]      addr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic                  err_o,
  output logic [WORDS-1:0]      mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  input  logic [DATA_WIDTH-1:0] mem_data_i,
  output logic                  mem_wr_no,
  output logic                  mem_rd_no
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_WRITE = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]            state_q, state_d;
  logic                  we_q;
  logic [2:0]            funct3_q;
  logic [WORDS+1:0]      addr_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [DATA_WIDTH-1:0] word_q;
  logic [DATA_WIDTH-1:0] rdata_q;

  logic                  accept;
  logic                  req_byte, req_half, req_word;
  logic [WORDS+1:0]      addr_eff;

  // Reserved size codes fall through to word width.
  assign req_byte = (funct3_i[1:0] == 2'b00);
  assign req_half = (funct3_i[1:0] == 2'b01);
  assign req_word = !req_byte && !req_half;
  assign accept   = (state_q == S_IDLE) && req_i;

  always_comb begin
    addr_eff = addr_i;
    if (req_half) addr_eff[0]   = 1'b0;
    if (req_word) addr_eff[1:0] = 2'b00;
  end

`ifdef MISALIGN_TRAP_EN
  logic misalign;
  logic err_q;

  assign misalign = (req_half && addr_i[0]) || (req_word && (addr_i[1:0] != 2'b00));

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      err_q <= 1'b0;
    end else if (accept) begin
      err_q <= misalign;
    end
  end

  assign err_o = err_q && (state_q == S_DONE);
`else
  assign err_o = 1'b0;
`endif

  function automatic logic [31:0] fmt_load(input logic [31:0] w, input logic [2:0] f3,
                                           input logic [1:0] a);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (a)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = a[1] ? w[31:16] : w[15:0];
    case (f3[1:0])
      2'b00:   r = f3[2] ? {24'h0, b} : {{24{b[7]}}, b};
      2'b01:   r = f3[2] ? {16'h0, h} : {{16{h[15]}}, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] merge_store(input logic [31:0] w, input logic [31:0] d,
                                              input logic [2:0] f3, input logic [1:0] a);
    logic [31:0] r;
    r = w;
    case (f3[1:0])
      2'b00: begin
        case (a)
          2'd0:    r[7:0]   = d[7:0];
          2'd1:    r[15:8]  = d[7:0];
          2'd2:    r[23:16] = d[7:0];
          default: r[31:24] = d[7:0];
        endcase
      end
      2'b01: begin
        if (a[1]) r[31:16] = d[15:0];
        else      r[15:0]  = d[15:0];
      end
      default: r = d;
    endcase
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (req_i) begin
`ifdef MISALIGN_TRAP_EN
          if (misalign)               state_d = S_DONE;
          else if (we_i && req_word)  state_d = S_WRITE;
          else                        state_d = S_READ;
`else
          if (we_i && req_word) state_d = S_WRITE;
          else                  state_d = S_READ;
`endif
        end
      end
      S_READ:  state_d = we_q ? S_WRITE : S_DONE;
      S_WRITE: state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      funct3_q <= 3'b000;
      addr_q   <= '0;
      wdata_q  <= '0;
      word_q   <= '0;
      rdata_q  <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q     <= we_i;
        funct3_q <= funct3_i;
        addr_q   <= addr_eff;
        wdata_q  <= wdata_i;
      end
      // Memory presents read data on the negedge inside READ.
      if (state_q == S_READ) begin
        word_q <= mem_data_i;
        if (!we_q) rdata_q <= fmt_load(mem_data_i, funct3_q, addr_q[1:0]);
      end
    end
  end

  assign rdata_o    = rdata_q;
  assign busy_o     = (state_q != S_IDLE);
  assign done_o     = (state_q == S_DONE);
  assign mem_addr_o = addr_q[WORDS+1:2];
  assign mem_data_o = merge_store(word_q, wdata_q, funct3_q, addr_q[1:0]);
  assign mem_rd_no  = (state_q != S_READ);
  assign mem_wr_no  = (state_q != S_WRITE);

endmodule

`default_nettype wire

// File: tb/tb_mem_access_unit.sv
//------------------------------------------------------------------------------
// tb_mem_access_unit : directed vector bench with a negedge-registered memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_access_unit;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk;
  logic        reset_ni;
  logic        req_i;
  logic        we_i;
  logic [2:0]  funct3_i;
  logic [11:0] addr_i;
  logic [31:0] wdata_i;
  logic [31:0] rdata_o;
  logic        busy_o;
  logic        done_o;
  logic        err_o;
  logic [9:0]  mem_addr_o;
  logic [31:0] mem_data_o;
  logic [31:0] mem_data_i;
  logic        mem_wr_no;
  logic        mem_rd_no;

  logic [31:0] mem [1024];

  int tests = 0;
  int fails = 0;

  mem_access_unit #(.WORDS(10), .DATA_WIDTH(32)) dut (
    .clk_i      (clk),
    .reset_ni   (reset_ni),
    .req_i      (req_i),
    .we_i       (we_i),
    .funct3_i   (funct3_i),
    .addr_i     (addr_i),
    .wdata_i    (wdata_i),
    .rdata_o    (rdata_o),
    .busy_o     (busy_o),
    .done_o     (done_o),
    .err_o      (err_o),
    .mem_addr_o (mem_addr_o),
    .mem_data_o (mem_data_o),
    .mem_data_i (mem_data_i),
    .mem_wr_no  (mem_wr_no),
    .mem_rd_no  (mem_rd_no)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (!mem_rd_no) mem_data_i = mem[mem_addr_o];
    if (!mem_wr_no) mem[mem_addr_o] = mem_data_o;
  end

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    int          exp_cyc;
    logic        exp_err;
    int          exp_rd;
    int          exp_wr;
    int          chk_idx;
    logic [31:0] exp_mem;
  } vec_t;

  localparam int NV = 15;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " rdata_o"},    rdata_o, 32'h0);
    check({tag, " done_o"},     {31'h0, done_o}, 32'h0);
    check({tag, " err_o"},      {31'h0, err_o}, 32'h0);
    check({tag, " busy_o"},     {31'h0, busy_o}, 32'h0);
    check({tag, " mem_wr_no"},  {31'h0, mem_wr_no}, 32'h1);
    check({tag, " mem_rd_no"},  {31'h0, mem_rd_no}, 32'h1);
    check({tag, " mem_data_o"}, mem_data_o, 32'h0);
    check({tag, " mem_addr_o"}, {22'h0, mem_addr_o}, 32'h0);
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    @(negedge clk);
    while (busy_o && guard < 20) begin
      @(negedge clk);
      guard++;
    end
  endtask

  // Cycle 1 is the accept cycle; outputs are sampled 1 time unit after each posedge.
  task automatic run_acc(input logic we, input logic [2:0] f3, input logic [11:0] a,
                         input logic [31:0] wd, output int done_cyc, output int rd_lo,
                         output int wr_lo, output logic err_seen);
    int cyc;
    wait_idle();
    we_i = we; funct3_i = f3; addr_i = a; wdata_i = wd; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    cyc = 2; done_cyc = 0; rd_lo = 0; wr_lo = 0; err_seen = 1'b0;
    for (int k = 0; k < 10 && done_cyc == 0; k++) begin
      if (!mem_rd_no) rd_lo++;
      if (!mem_wr_no) wr_lo++;
      if (done_o) begin
        done_cyc = cyc;
        err_seen = err_o;
      end else begin
        @(posedge clk); #1;
        cyc++;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int dc, rl, wl;
    logic es;
    int d1, d2, idle_between;
    logic [31:0] r1, r2;

    req_i = 0; we_i = 0; funct3_i = 3'b000; addr_i = '0; wdata_i = '0;
    mem_data_i = 32'h0;
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[5]  = 32'h1111000B;
    mem[7]  = 32'h77777777;
    mem[10] = 32'h80FF7F01;
    mem[41] = 32'h41414141;
    mem[42] = 32'hD0B0A090;

    //              we  f3      addr     wdata         rdata                         cyc          err   rd          wr          idx   mem
    vecs[0]  = '{1'b0, 3'b000, 12'h0AB, 32'h0,        32'hFFFFFFD0,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[1]  = '{1'b0, 3'b100, 12'h0AB, 32'h0,        32'h000000D0,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[2]  = '{1'b0, 3'b001, 12'h0A8, 32'h0,        32'hFFFFA090,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[3]  = '{1'b0, 3'b101, 12'h0AA, 32'h0,        32'h0000D0B0,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[4]  = '{1'b0, 3'b010, 12'h0A8, 32'h0,        32'hD0B0A090,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[5]  = '{1'b1, 3'b001, 12'h016, 32'h00001234, 32'hD0B0A090,                 4,           1'b0, 1,          1,          5,    32'h1234000B};
    vecs[6]  = '{1'b1, 3'b010, 12'hFFC, 32'hDEADBEEF, 32'hD0B0A090,                 3,           1'b0, 0,          1,          1023, 32'hDEADBEEF};
    vecs[7]  = '{1'b1, 3'b000, 12'h029, 32'hFFFFFFAA, 32'hD0B0A090,                 4,           1'b0, 1,          1,          10,   32'h80FFAA01};
    vecs[8]  = '{1'b0, 3'b000, 12'h028, 32'h0,        32'h00000001,                 3,           1'b0, 1,          0,          10,   32'h80FFAA01};
    vecs[9]  = '{1'b0, 3'b100, 12'h02B, 32'h0,        32'h00000080,                 3,           1'b0, 1,          0,          10,   32'h80FFAA01};
    vecs[10] = '{1'b0, 3'b010, 12'h0A9, 32'h0,        TRAP ? 32'h00000080 : 32'hD0B0A090,
                 TRAP ? 2 : 3, TRAP, TRAP ? 0 : 1, 0, 42, 32'hD0B0A090};
    vecs[11] = '{1'b1, 3'b001, 12'h017, 32'h00005678, TRAP ? 32'h00000080 : 32'hD0B0A090,
                 TRAP ? 2 : 4, TRAP, TRAP ? 0 : 1, TRAP ? 0 : 1, 5, TRAP ? 32'h1234000B : 32'h5678000B};
    vecs[12] = '{1'b0, 3'b001, 12'h0A9, 32'h0,        TRAP ? 32'h00000080 : 32'hFFFFA090,
                 TRAP ? 2 : 3, TRAP, TRAP ? 0 : 1, 0, 42, 32'hD0B0A090};
    vecs[13] = '{1'b0, 3'b011, 12'h0A8, 32'h0,        32'hD0B0A090,                 3,           1'b0, 1,          0,          42,   32'hD0B0A090};
    vecs[14] = '{1'b0, 3'b110, 12'h0A4, 32'h0,        32'h41414141,                 3,           1'b0, 1,          0,          41,   32'h41414141};

    reset_ni = 1'b0;
    #2;
    check_reset_outputs("por");
    #30;
    reset_ni = 1'b1;

    for (int i = 0; i < NV; i++) begin
      run_acc(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, dc, rl, wl, es);
      check($sformatf("v%0d done_cycle", i), dc, vecs[i].exp_cyc);
      check($sformatf("v%0d rdata", i), rdata_o, vecs[i].exp_rdata);
      check($sformatf("v%0d err", i), {31'h0, es}, {31'h0, vecs[i].exp_err});
      check($sformatf("v%0d rd_strobes", i), rl, vecs[i].exp_rd);
      check($sformatf("v%0d wr_strobes", i), wl, vecs[i].exp_wr);
      check($sformatf("v%0d mem_word", i), mem[vecs[i].chk_idx], vecs[i].exp_mem);
    end

    // Request held high across two loads.
    wait_idle();
    we_i = 1'b0; funct3_i = 3'b010; addr_i = 12'h0A8; req_i = 1'b1;
    d1 = 0; d2 = 0; idle_between = 0; r1 = 32'h0; r2 = 32'h0;
    for (int c = 2; c <= 6; c++) begin
      @(posedge clk); #1;
      if (c == 2) addr_i = 12'h028;
      if (done_o && d1 == 0) begin
        d1 = c; r1 = rdata_o;
      end else if (done_o && d2 == 0) begin
        d2 = c; r2 = rdata_o;
      end
      if (!busy_o && d1 != 0 && d2 == 0) idle_between++;
    end
    req_i = 1'b0;
    check("held first_done_cycle", d1, 3);
    check("held second_done_cycle", d2, 6);
    check("held idle_gap", idle_between, 1);
    check("held first_rdata", r1, 32'hD0B0A090);
    check("held second_rdata", r2, 32'h80FFAA01);

    // Reset asserted while the write strobe is active, before the memory negedge.
    wait_idle();
    we_i = 1'b1; funct3_i = 3'b010; addr_i = 12'h01C; wdata_i = 32'hCAFEF00D; req_i = 1'b1;
    @(posedge clk); #1;
    req_i = 1'b0;
    check("midrst wr_strobe_before", {31'h0, mem_wr_no}, 32'h0);
    reset_ni = 1'b0;
    #1;
    check_reset_outputs("midrst");
    @(posedge clk); #1;
    reset_ni = 1'b1;
    check("midrst mem7_unchanged", mem[7], 32'h77777777);

    run_acc(1'b0, 3'b010, 12'h01C, 32'h0, dc, rl, wl, es);
    check("postrst load_cycle", dc, 3);
    check("postrst load_rdata", rdata_o, 32'h77777777);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
